// File: rtl/alu_mc_if.sv
// Request/response bundle for alu_mc_pipe.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready
// are both high in that cycle. The source keeps valid high, and its payload
// stable, until the transfer happens. ready may depend on the sink's state
// and on out_ready, but never on in_valid.
//   input side : in_valid/in_ready carry opcode, operand1, operand2
//   output side: out_valid/out_ready carry result, err
// flags and dbg_state are status outputs with no handshake
// (dbg_state: 0=IDLE, 1=BUSY, 2=DONE).
interface alu_mc_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             err;
  logic [2:0]       flags;
  logic [1:0]       dbg_state;

  modport master (
    output in_valid, opcode, operand1, operand2, out_ready,
    input  in_ready, out_valid, result, err, flags, dbg_state
  );

  modport slave (
    input  in_valid, opcode, operand1, operand2, out_ready,
    output in_ready, out_valid, result, err, flags, dbg_state
  );
endinterface

// File: rtl/alu_mc_pipe.sv
// Handshaked ALU with a one-deep result register, a flag register updated
// on result handoff, and a multi-cycle shift-add multiplier.
module alu_mc_pipe #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic     clk,
  input logic     rst,
  alu_mc_if.slave bus
);
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_XOR = 4'd2;
  localparam logic [3:0] OP_RED = 4'd3;
  localparam logic [3:0] OP_SLL = 4'd4;
  localparam logic [3:0] OP_SRA = 4'd5;
  localparam logic [3:0] OP_ROR = 4'd6;
  localparam logic [3:0] OP_PAD = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam int         CW     = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic             in_ready, out_valid, accept, handoff, is_mul;
  logic [WIDTH-1:0] result_q, mcand_q, mplier_q, acc_q, step_sum;
  logic             err_q, v_q;
  logic [3:0]       op_q;
  logic [CW-1:0]    cnt_q;
  logic [2:0]       flags_q;

  logic [WIDTH-1:0] a, b, calc_res, red, padd, rot;
  logic             calc_err, calc_v;
  logic [WIDTH:0]   sum_ext, diff_ext;
  logic [4:0]       lane_sum;
  logic [SHW-1:0]   sh;
  logic [SHW:0]     lsh;

  assign a        = bus.operand1;
  assign b        = bus.operand2;
  assign sh       = b[SHW-1:0];
  assign is_mul   = (bus.opcode == OP_MUL);
  assign accept   = bus.in_valid & in_ready;
  assign handoff  = out_valid & bus.out_ready;
  assign step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.result    = result_q;
  assign bus.err       = err_q;
  assign bus.flags     = flags_q;
  assign bus.dbg_state = state_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and handshake outputs; DONE can accept when the result leaves.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) state_d = is_mul ? BUSY : DONE;
      end
      BUSY: begin
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = bus.out_ready;
        if (accept)             state_d = is_mul ? BUSY : DONE;
        else if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Single-cycle results computed straight from the request.
  always_comb begin
    calc_res = '0;
    calc_err = 1'b0;
    calc_v   = 1'b0;
    red      = '0;
    padd     = '0;
    lane_sum = '0;
    sum_ext  = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    diff_ext = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    lsh      = (SHW+1)'(WIDTH) - {1'b0, sh};
    rot      = (a >> sh) | (a << lsh);
    for (int i = 0; i < WIDTH/4; i++) begin
      red = red + {{(WIDTH-4){a[4*i+3]}}, a[4*i +: 4]}
                + {{(WIDTH-4){b[4*i+3]}}, b[4*i +: 4]};
      lane_sum = {a[4*i+3], a[4*i +: 4]} + {b[4*i+3], b[4*i +: 4]};
      if (lane_sum[4] != lane_sum[3])
        padd[4*i +: 4] = lane_sum[4] ? 4'b1000 : 4'b0111;
      else
        padd[4*i +: 4] = lane_sum[3:0];
    end
    case (bus.opcode)
      OP_ADD: begin
        calc_v   = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];
        calc_res = calc_v ? {sum_ext[WIDTH], {(WIDTH-1){~sum_ext[WIDTH]}}}
                          : sum_ext[WIDTH-1:0];
      end
      OP_SUB: begin
        calc_v   = diff_ext[WIDTH] ^ diff_ext[WIDTH-1];
        calc_res = calc_v ? {diff_ext[WIDTH], {(WIDTH-1){~diff_ext[WIDTH]}}}
                          : diff_ext[WIDTH-1:0];
      end
      OP_XOR:  calc_res = a ^ b;
      OP_RED:  calc_res = red;
      OP_SLL:  calc_res = a << sh;
      OP_SRA:  calc_res = $unsigned($signed(a) >>> sh);
      OP_ROR:  calc_res = rot;
      OP_PAD:  calc_res = padd;
      OP_MUL:  calc_res = '0;
      default: calc_err = 1'b1;
    endcase
  end

  // Result register and shift-add multiplier (one partial product per cycle).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      err_q    <= 1'b0;
      v_q      <= 1'b0;
      op_q     <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (accept) begin
      op_q <= bus.opcode;
      if (is_mul) begin
        mcand_q  <= a;
        mplier_q <= b;
        acc_q    <= '0;
        cnt_q    <= CW'(WIDTH-1);
        err_q    <= 1'b0;
        v_q      <= 1'b0;
      end else begin
        result_q <= calc_res;
        err_q    <= calc_err;
        v_q      <= calc_v;
      end
    end else if (state_q == BUSY) begin
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      acc_q    <= step_sum;
      cnt_q    <= cnt_q - 1'b1;
      if (cnt_q == '0) result_q <= step_sum;
    end
  end

  // Flags follow the result as it is handed off, masked by its opcode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= 3'b000;
    end else if (handoff) begin
      case (op_q)
        OP_ADD, OP_SUB:
          flags_q <= {v_q, result_q[WIDTH-1], (result_q == '0)};
        OP_XOR, OP_SLL, OP_SRA, OP_ROR, OP_MUL:
          flags_q[0] <= (result_q == '0);
        default: ;
      endcase
    end
  end
endmodule
